// File: rtl/accel_axis_sampler.sv
// Accelerometer axis sampler: writes the sensor init table over SPI, then polls
// status on interrupt or idle timeout and bursts the axis bytes into oSAMPLE.
module accel_axis_sampler #(
  parameter int unsigned NUM_AXES   = 3,
  parameter int unsigned INI_NUMBER = 11,
  parameter int unsigned IDLE_MSB   = 14,
  parameter logic [5:0]  BASE_ADDR  = 6'h32
) (
  input  logic                     iSPI_CLK,
  input  logic                     iRST,
  input  logic                     iG_INT,
  input  logic                     iCFG_WR,
  input  logic [5:0]               iCFG_ADDR,
  input  logic [7:0]               iCFG_DATA,
  output logic                     oCFG_BUSY,
  output logic [15:0]              oP2S_DATA,
  output logic                     oSPI_GO,
  input  logic                     iSPI_END,
  input  logic [7:0]               iS2P_DATA,
  output logic [NUM_AXES*16-1:0]   oSAMPLE,
  output logic                     oSAMPLE_VALID,
  output logic                     oINIT_DONE
);

  localparam int unsigned SAMPLE_W  = NUM_AXES * 16;
  localparam int unsigned NBYTES    = 2 * NUM_AXES;
  localparam logic [5:0]  STAT_ADDR = 6'h30;
  localparam logic [2:0]  HOLDOFF   = 3'd4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    XFER_INIT,
    XFER_CFG,
    XFER_STAT,
    XFER_DATA
  } state_t;

  function automatic logic [15:0] init_word(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'h2420;
      4'd1:    return 16'h2503;
      4'd2:    return 16'h2601;
      4'd3:    return 16'h277F;
      4'd4:    return 16'h2809;
      4'd5:    return 16'h2946;
      4'd6:    return 16'h2C09;
      4'd7:    return 16'h2E80;
      4'd8:    return 16'h2F00;
      4'd9:    return 16'h3140;
      4'd10:   return 16'h2D08;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] wr_word(input logic [5:0] addr, input logic [7:0] data);
    return {1'b0, 1'b0, addr, data};
  endfunction

  function automatic logic [15:0] rd_word(input logic [5:0] addr);
    return {1'b1, 1'b0, addr, 8'h00};
  endfunction

  state_t                state, state_n;
  logic [3:0]            init_idx, init_idx_n;
  logic [2:0]            byte_idx, byte_idx_n;
  logic [15:0]           idle_cnt, idle_cnt_n;
  logic [2:0]            holdoff, holdoff_n;
  logic                  cfg_pend, cfg_pend_n;
  logic [5:0]            cfg_addr, cfg_addr_n;
  logic [7:0]            cfg_data, cfg_data_n;
  logic [SAMPLE_W-1:0]   shadow, shadow_n;
  logic                  go_n;
  logic [15:0]           p2s_n;
  logic [SAMPLE_W-1:0]   sample_n;
  logic                  valid_n;
  logic                  init_done_n;
  logic                  busy_n;
  logic                  xfer_end;
  logic [5:0]            data_addr;

  assign xfer_end  = oSPI_GO && iSPI_END;
  assign data_addr = BASE_ADDR + 6'(byte_idx);

  // State and output registers
  always_ff @(posedge iSPI_CLK or posedge iRST) begin
    if (iRST) begin
      state         <= INIT;
      init_idx      <= 4'd0;
      byte_idx      <= 3'd0;
      idle_cnt      <= 16'd0;
      holdoff       <= 3'd0;
      cfg_pend      <= 1'b0;
      cfg_addr      <= 6'd0;
      cfg_data      <= 8'd0;
      shadow        <= '0;
      oSPI_GO       <= 1'b0;
      oP2S_DATA     <= 16'd0;
      oSAMPLE       <= '0;
      oSAMPLE_VALID <= 1'b0;
      oINIT_DONE    <= 1'b0;
      oCFG_BUSY     <= 1'b1;
    end else begin
      state         <= state_n;
      init_idx      <= init_idx_n;
      byte_idx      <= byte_idx_n;
      idle_cnt      <= idle_cnt_n;
      holdoff       <= holdoff_n;
      cfg_pend      <= cfg_pend_n;
      cfg_addr      <= cfg_addr_n;
      cfg_data      <= cfg_data_n;
      shadow        <= shadow_n;
      oSPI_GO       <= go_n;
      oP2S_DATA     <= p2s_n;
      oSAMPLE       <= sample_n;
      oSAMPLE_VALID <= valid_n;
      oINIT_DONE    <= init_done_n;
      oCFG_BUSY     <= busy_n;
    end
  end

  // Next-state and output logic; each XFER state raises GO with a fresh word
  // when GO is low, and drops it for a cycle once the controller reports END.
  always_comb begin
    state_n     = state;
    init_idx_n  = init_idx;
    byte_idx_n  = byte_idx;
    idle_cnt_n  = idle_cnt;
    holdoff_n   = (holdoff != 3'd0) ? holdoff - 3'd1 : 3'd0;
    cfg_pend_n  = cfg_pend;
    cfg_addr_n  = cfg_addr;
    cfg_data_n  = cfg_data;
    shadow_n    = shadow;
    go_n        = oSPI_GO;
    p2s_n       = oP2S_DATA;
    sample_n    = oSAMPLE;
    valid_n     = 1'b0;
    init_done_n = oINIT_DONE;
    busy_n      = oCFG_BUSY;

    if (iCFG_WR && !oCFG_BUSY) begin
      cfg_pend_n = 1'b1;
      cfg_addr_n = iCFG_ADDR;
      cfg_data_n = iCFG_DATA;
      busy_n     = 1'b1;
    end

    case (state)
      INIT: state_n = XFER_INIT;

      IDLE: begin
        if (cfg_pend) begin
          cfg_pend_n = 1'b0;
          state_n    = XFER_CFG;
        end else if ((iG_INT && holdoff == 3'd0) || idle_cnt[IDLE_MSB]) begin
          idle_cnt_n = 16'd0;
          state_n    = XFER_STAT;
        end else begin
          idle_cnt_n = idle_cnt + 16'd1;
        end
      end

      XFER_INIT: begin
        if (!oSPI_GO) begin
          go_n  = 1'b1;
          p2s_n = init_word(init_idx);
        end else if (xfer_end) begin
          go_n = 1'b0;
          if (init_idx == 4'(INI_NUMBER - 1)) begin
            init_done_n = 1'b1;
            busy_n      = 1'b0;
            state_n     = IDLE;
          end else begin
            init_idx_n = init_idx + 4'd1;
            state_n    = INIT;
          end
        end
      end

      XFER_CFG: begin
        if (!oSPI_GO) begin
          go_n  = 1'b1;
          p2s_n = wr_word(cfg_addr, cfg_data);
        end else if (xfer_end) begin
          go_n    = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end

      XFER_STAT: begin
        if (!oSPI_GO) begin
          go_n  = 1'b1;
          p2s_n = rd_word(STAT_ADDR);
        end else if (xfer_end) begin
          go_n      = 1'b0;
          holdoff_n = HOLDOFF;
          if (iS2P_DATA[7]) begin
            byte_idx_n = 3'd0;
            state_n    = XFER_DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end

      XFER_DATA: begin
        if (!oSPI_GO) begin
          go_n  = 1'b1;
          p2s_n = rd_word(data_addr);
        end else if (xfer_end) begin
          go_n = 1'b0;
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (byte_idx == 3'(b)) shadow_n[8*b +: 8] = iS2P_DATA;
          end
          if (byte_idx == 3'(NBYTES - 1)) begin
            sample_n = shadow_n;
            valid_n  = 1'b1;
            state_n  = IDLE;
          end else begin
            byte_idx_n = byte_idx + 3'd1;
          end
        end
      end

      default: state_n = INIT;
    endcase
  end

endmodule

// File: tb/tb_accel_axis_sampler.sv
// Bench for accel_axis_sampler: SPI controller model with an expected-word
// scoreboard, driving a 3-axis and a 1-axis instance side by side.
module tb_accel_axis_sampler;

  localparam int XFER_CYC = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        g_int0, g_int1;
  logic        cfg_wr, cfg_wr1;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        busy0, busy1;
  logic [15:0] p2s0, p2s1;
  logic        go0, go1;
  logic        end0, end1;
  logic [7:0]  s2p0, s2p1;
  logic [47:0] sample0;
  logic [15:0] sample1;
  logic        valid0, valid1;
  logic        done0, done1;

  logic [15:0] exp_w0[$], exp_w1[$];
  logic [7:0]  resp0[$], resp1[$];
  logic [47:0] samp_q0[$];
  logic [15:0] samp_q1[$];
  logic [15:0] init_tbl[11] = '{16'h2420, 16'h2503, 16'h2601, 16'h277F, 16'h2809, 16'h2946,
                                16'h2C09, 16'h2E80, 16'h2F00, 16'h3140, 16'h2D08};

  int cyc = 0;
  int served[2] = '{0, 0};
  int last_end[2] = '{0, 0};
  int gap[2] = '{0, 0};
  int vcount[2] = '{0, 0};
  int cnt0 = 0, cnt1 = 0;
  int total = 0, bad = 0;
  int base0, base1;

  accel_axis_sampler dut0 (
    .iSPI_CLK(clk), .iRST(rst), .iG_INT(g_int0), .iCFG_WR(cfg_wr),
    .iCFG_ADDR(cfg_addr), .iCFG_DATA(cfg_data), .oCFG_BUSY(busy0),
    .oP2S_DATA(p2s0), .oSPI_GO(go0), .iSPI_END(end0), .iS2P_DATA(s2p0),
    .oSAMPLE(sample0), .oSAMPLE_VALID(valid0), .oINIT_DONE(done0)
  );

  accel_axis_sampler #(.NUM_AXES(1), .INI_NUMBER(1)) dut1 (
    .iSPI_CLK(clk), .iRST(rst), .iG_INT(g_int1), .iCFG_WR(cfg_wr1),
    .iCFG_ADDR(cfg_addr), .iCFG_DATA(cfg_data), .oCFG_BUSY(busy1),
    .oP2S_DATA(p2s1), .oSPI_GO(go1), .iSPI_END(end1), .iS2P_DATA(s2p1),
    .oSAMPLE(sample1), .oSAMPLE_VALID(valid1), .oINIT_DONE(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Controller model: END pulses after XFER_CYC cycles of GO; the word is
  // checked against the scoreboard and the queued read byte is returned.
  task automatic serve(input int u, input logic go, input logic [15:0] word,
                       inout logic send, inout logic [7:0] rd, inout int cnt);
    logic [15:0] ew;
    logic [7:0]  rb;
    bit          unexp;
    if (send) begin
      send = 1'b0;
      cnt  = 0;
    end else if (!go) begin
      cnt = 0;
    end else begin
      if (cnt == 0) gap[u] = cyc - last_end[u];
      cnt++;
      if (cnt == XFER_CYC) begin
        ew = 16'h0; rb = 8'h0; unexp = 1'b0;
        if (u == 0 && exp_w0.size() != 0) begin
          ew = exp_w0.pop_front(); rb = resp0.pop_front();
        end else if (u == 1 && exp_w1.size() != 0) begin
          ew = exp_w1.pop_front(); rb = resp1.pop_front();
        end else begin
          unexp = 1'b1;
        end
        // 17-bit expectation: no 16-bit word can match an unscheduled transfer
        if (unexp) chk(u == 0 ? "xfer0_unexpected" : "xfer1_unexpected", 64'(word), 64'h1_0000);
        else       chk(u == 0 ? "xfer0_word" : "xfer1_word", 64'(word), 64'(ew));
        rd          = rb;
        send        = 1'b1;
        last_end[u] = cyc;
        served[u]++;
      end
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 11; i++) begin
      exp_w0.push_back(init_tbl[i]);
      resp0.push_back(8'h00);
    end
    exp_w1.push_back(16'h2420);
    resp1.push_back(8'h00);
  endtask

  initial begin
    end0 = 1'b0; end1 = 1'b0; s2p0 = 8'h0; s2p1 = 8'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (valid0) begin
        vcount[0]++;
        chk("samp0_latency", 64'(cyc - last_end[0]), 64'd1);
        if (samp_q0.size() != 0) chk("samp0_value", 64'(sample0), 64'(samp_q0.pop_front()));
      end
      if (valid1) begin
        vcount[1]++;
        chk("samp1_latency", 64'(cyc - last_end[1]), 64'd1);
        if (samp_q1.size() != 0) chk("samp1_value", 64'(sample1), 64'(samp_q1.pop_front()));
      end
      if (rst) begin
        end0 = 1'b0; end1 = 1'b0; cnt0 = 0; cnt1 = 0;
      end else begin
        serve(0, go0, p2s0, end0, s2p0, cnt0);
        serve(1, go1, p2s1, end1, s2p1, cnt1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; g_int0 = 1'b0; g_int1 = 1'b0;
    cfg_wr = 1'b0; cfg_wr1 = 1'b0; cfg_addr = 6'h0; cfg_data = 8'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_go", 64'(go0), 64'd0);
    chk("rst_p2s", 64'(p2s0), 64'd0);
    chk("rst_sample", 64'(sample0), 64'd0);
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd1);
    chk("rst_sample1", 64'(sample1), 64'd0);

    // Reset during the 5th init write
    push_init();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #2;
      if (served[0] == 4 && go0) break;
    end
    chk("init_reach5", 64'(served[0]), 64'd4);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_go", 64'(go0), 64'd0);
    chk("midrst_p2s", 64'(p2s0), 64'd0);
    chk("midrst_busy", 64'(busy0), 64'd1);
    exp_w0.delete(); resp0.delete(); exp_w1.delete(); resp1.delete();
    served = '{0, 0};
    push_init();
    @(posedge clk); #2;
    rst = 1'b0;

    // Full init sequence
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #2;
      if (done0) break;
    end
    chk("init_done", 64'(done0), 64'd1);
    chk("done_latency", 64'(cyc - last_end[0]), 64'd1);
    chk("init_busy_low", 64'(busy0), 64'd0);
    chk("init_words_left", 64'(exp_w0.size()), 64'd0);
    chk("init_done1", 64'(done1), 64'd1);
    chk("init_busy1_low", 64'(busy1), 64'd0);

    // Interrupt-driven burst on both units, cfg write arriving mid-burst on unit 0
    base0 = served[0];
    exp_w0.push_back(16'hB000); resp0.push_back(8'h80);
    for (int k = 0; k < 6; k++) begin
      exp_w0.push_back({8'hB2 + 8'(k), 8'h00});
      resp0.push_back(8'h11 * 8'(k + 1));
    end
    samp_q0.push_back(48'h6655_4433_2211);
    exp_w1.push_back(16'hB000); resp1.push_back(8'h80);
    exp_w1.push_back(16'hB200); resp1.push_back(8'h34);
    exp_w1.push_back(16'hB300); resp1.push_back(8'h12);
    samp_q1.push_back(16'h1234);
    g_int0 = 1'b1; g_int1 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #2;
      if (go0) g_int0 = 1'b0;
      if (go1) g_int1 = 1'b0;
      if (!g_int0 && !g_int1) break;
    end
    chk("poll_started0", 64'(go0), 64'd1);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #2;
      if (served[0] == base0 + 2) break;
    end
    chk("burst_underway", 64'(served[0]), 64'(base0 + 2));
    cfg_wr = 1'b1; cfg_addr = 6'h2C; cfg_data = 8'h0A;
    exp_w0.push_back(16'h2C0A); resp0.push_back(8'h00);
    @(posedge clk); #2;
    cfg_wr = 1'b0;
    chk("cfg_busy_rise", 64'(busy0), 64'd1);
    cfg_wr = 1'b1; cfg_addr = 6'h11; cfg_data = 8'h77;
    @(posedge clk); #2;
    cfg_wr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      if (exp_w0.size() == 0 && !busy0) break;
    end
    chk("cfg_busy_fall", 64'(busy0), 64'd0);
    chk("busy_fall_latency", 64'(cyc - last_end[0]), 64'd1);
    chk("burst_cfg_left", 64'(exp_w0.size()), 64'd0);
    chk("sample0_final", 64'(sample0), 64'h6655_4433_2211);
    chk("valid0_pulses", 64'(vcount[0]), 64'd1);
    chk("burst1_left", 64'(exp_w1.size()), 64'd0);
    chk("sample1_final", 64'(sample1), 64'h1234);
    chk("valid1_pulses", 64'(vcount[1]), 64'd1);

    // Holdoff: interrupt held high, status with no data ready twice
    base1 = served[1];
    exp_w1.push_back(16'hB000); resp1.push_back(8'h00);
    exp_w1.push_back(16'hB000); resp1.push_back(8'h00);
    g_int1 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #2;
      if (served[1] == base1 + 2) break;
    end
    g_int1 = 1'b0;
    chk("holdoff_polls", 64'(served[1]), 64'(base1 + 2));
    chk("holdoff_gap", 64'(gap[1]), 64'd7);

    // Idle-timeout poll with no data ready
    exp_w0.push_back(16'hB000); resp0.push_back(8'h00);
    exp_w1.push_back(16'hB000); resp1.push_back(8'h00);
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #2;
      if (exp_w0.size() == 0 && exp_w1.size() == 0) break;
    end
    chk("idle_poll0", 64'(exp_w0.size()), 64'd0);
    chk("idle_poll1", 64'(exp_w1.size()), 64'd0);
    chk("idle_gap0", 64'(gap[0]), 64'd16387);
    repeat (40) @(posedge clk);
    #2;
    chk("idle_sample_hold", 64'(sample0), 64'h6655_4433_2211);
    chk("idle_no_valid0", 64'(vcount[0]), 64'd1);
    chk("idle_no_valid1", 64'(vcount[1]), 64'd1);
    chk("idle_go_low", 64'(go0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
